dispatch_demux4: RTL
====================

Name: dispatch_demux4

Overview:
- One-to-four dispatch demultiplexer: one producer stream with a 2-bit destination select is routed into one of four independent per-lane FIFOs, each with its own consumer.
- It is the fan-out counterpart of the 4:1 data-select muxes in the dynamic pipeline. It sits between issue and the four execution-unit/reservation-station queues.
- Valid/ready handshake on both sides, so producer and consumers can stall independently.

Parameters:
- DATA_W, 32, width of each dispatched word.
- DEPTH, 2, entries per lane FIFO; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous clear of all lanes (pipeline flush); same effect as rst on datapath state.
- in_valid  input  1  producer word valid.
- in_ready  output  1  lane selected by in_sel can accept.
- in_sel  input  2  destination lane 0..3.
- in_data  input  DATA_W  word to dispatch.
- out_valid  output  4  bit i: lane i head valid.
- out_ready  input  4  bit i: consumer i takes head.
- out_data  output  4*DATA_W  lane i head at bits [i*DATA_W +: DATA_W].

Behaviour:
- Per-lane state:
  - Write pointer and read pointer, log2(DEPTH) bits each, wrapping modulo DEPTH.
  - Count register of width clog2(DEPTH+1).
- Handshake:
  - Push on lane in_sel when in_valid && in_ready.
  - Pop on lane i when out_valid[i] && out_ready[i].
- in_ready = !full[in_sel] && !flush.
  - in_ready is combinational from in_sel, count and flush only. There is no path from out_ready to in_ready.
  - A full lane therefore refuses a push even if it pops in the same cycle.
- out_valid[i] = (count[i] != 0). out_data lane i = storage at the read pointer, driven from registers.
- Latency: a word pushed at edge N appears with out_valid high after edge N, i.e. 1 cycle. There is no bypass.
- Simultaneous push and pop on the same non-full, non-empty lane: count is unchanged and both pointers advance.
- Push into an empty lane while out_ready[i]=1: no pop that cycle, because out_valid[i] is 0.
- Per-lane order is FIFO. Between lanes there is no ordering guarantee.
- in_sel and in_data are ignored when in_valid=0. Unselected lanes never see a push.
- Pushes occur only on the lane named by in_sel. A blocked word does not block pushes to other lanes on later cycles, because the producer may change in_sel.
- rst or flush:
  - All pointers and counts go to 0 at the next edge, and any push/pop in that cycle is discarded.
  - Priority: rst > flush > push/pop.
  - Storage contents need not be cleared.
- Reset values: out_valid=4'b0000, in_ready=0 while rst is high, out_data don't-care but deterministic (storage reset to 0 is acceptable).

Optional Feature:
- Macro DISPATCH_DEMUX_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0]: saturating count of cycles with in_valid && !in_ready.
  - Cleared by rst and not by flush. Holds at 16'hFFFF.
- Undefined: the port and its logic are absent, and the block behaves identically otherwise.

Decomposition:
- Shared package (cpu_pkg):
  - LANES=4 constant.
  - lane_sel_t typedef (2-bit).
  - DATA_W default constant.
- One sub-module: lane_fifo (DATA_W, DEPTH) with push/pop/flush/full/empty/head. It is instantiated four times with a generate loop.
- Top level holds the in_sel decode, the in_ready mux and the optional stats counter.

Test Plan:
- Reset then single push: rst 2 cycles; in_sel=2, in_data=32'hA5A5_0001 for one cycle → out_valid=4'b0100 on the next cycle, lane 2 data=32'hA5A5_0001, other lanes invalid.
- Fill and backpressure: out_ready=0; push 3 words to lane 1 (32'h10, 32'h11, 32'h12) → in_ready drops after 2 pushes and the third is held. Raise out_ready[1] → pops 32'h10, then 32'h11 (the held 32'h12 is accepted in the cycle after the first pop), then 32'h12, in order.
- Lane independence: lane 0 full, in_sel=0 stalled; switch in_sel=3 with 32'hBEEF → accepted the same cycle, out_valid[3]=1 next cycle, lane 0 still holds 2 entries.
- Concurrent push/pop: lane 2 holds 1 entry, out_ready[2]=1, push 32'h22 to lane 2 → count stays 1. Head changes to 32'h22 next cycle. Pointer wrap is exercised over 5 iterations.
- Flush mid-operation: all lanes hold data; flush=1 with in_valid=1 → in_ready=0, next cycle out_valid=0000, the pushed word is lost. A push after flush lands correctly.
- Stats (with DISPATCH_DEMUX_STATS_EN): hold in_valid against a full lane for 7 cycles → stall_cnt=7. flush leaves it at 7; rst clears it to 0.

Source files
------------

// File: rtl/dispatch_demux4_pkg.sv
// dispatch_demux4_pkg: shared lane count, lane select type and default word width
package dispatch_demux4_pkg;
    localparam int LANES = 4;
    localparam int DATA_W_DEF = 32;
    typedef logic [1:0] lane_sel_t;
endpackage

// File: rtl/dispatch_demux4_lane_fifo.sv
// dispatch_demux4_lane_fifo: per-lane FIFO with registered head, no bypass
module dispatch_demux4_lane_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign head  = mem[rp];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (push && !flush) begin
            mem[wp] <= din;
        end
    end
endmodule

// File: rtl/dispatch_demux4.sv
// dispatch_demux4: 1-to-4 dispatch demux into per-lane FIFOs; DISPATCH_DEMUX_STATS_EN adds stall_cnt
module dispatch_demux4
    import dispatch_demux4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_sel,
    input  logic [DATA_W-1:0]       in_data,
    output logic [LANES-1:0]        out_valid,
    input  logic [LANES-1:0]        out_ready,
    output logic [LANES*DATA_W-1:0] out_data
`ifdef DISPATCH_DEMUX_STATS_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);
    lane_sel_t sel;
    logic [LANES-1:0] full, empty;
    assign sel = in_sel;
    // readiness ignores out_ready so a full lane never accepts on a same-cycle pop
    assign in_ready = !full[sel] && !flush && !rst;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dispatch_demux4_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .flush(flush),
            .push (in_valid && in_ready && sel == lane_sel_t'(i)),
            .pop  (out_valid[i] && out_ready[i]),
            .din  (in_data),
            .full (full[i]),
            .empty(empty[i]),
            .head (out_data[i*DATA_W +: DATA_W])
        );
        assign out_valid[i] = !empty[i];
    end
`ifdef DISPATCH_DEMUX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= '0;
        else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule
